// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB register-file slave.
// byte_merge is only used when APB_SLAVE_PSTRB_EN is defined.
package apb_slv_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

  localparam int MAX_DATA_WIDTH = 32;
  localparam int BYTES          = MAX_DATA_WIDTH / 8;

  // Narrower data widths are zero-extended into the widest word.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [BYTES-1:0]          strb
  );
    logic [MAX_DATA_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < BYTES; i++) begin
      if (strb[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/apb_slave_wait_ctr.sv
// Wait-state counter: loads a terminal value at setup, counts up during the access
// phase and flags the increment that reaches the terminal value.
module apb_slave_wait_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc_next
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] term_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      term_reg  <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
      term_reg  <= load_value;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Extra bit keeps the compare exact when the terminal value is all ones.
  assign tc_next = (({1'b0, count_reg} + 1'b1) == {1'b0, term_reg});

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 word-addressed register file with programmable wait states and PSLVERR decode.
// Define APB_SLAVE_PSTRB_EN for APB4 byte strobes (pstrb port).
module apb_slave_regfile
  import apb_slv_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int                    MAX_WAIT   = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            psel,
  input  logic                            penable,
  input  logic                            pwrite,
  input  logic [ADDR_WIDTH-1:0]           paddr,
  input  logic [DATA_WIDTH-1:0]           pwdata,
`ifdef APB_SLAVE_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]         pstrb,
`endif
  input  logic [$clog2(MAX_WAIT+1)-1:0]   cfg_wait,
  output logic [DATA_WIDTH-1:0]           prdata,
  output logic                            pready,
  output logic                            pslverr
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CW    = $clog2(MAX_WAIT + 1);
  localparam int SPAN  = DEPTH * NB;

  apb_slv_state_e state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      idx_reg;
  logic                  err_reg;
  logic                  write_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
`ifdef APB_SLAVE_PSTRB_EN
  logic [NB-1:0]         strb_reg;
`endif

  logic [DATA_WIDTH-1:0] prdata_next;
  logic                  pready_next;
  logic                  pslverr_next;
  logic                  ctr_load, ctr_clear, ctr_inc, ctr_tc_next;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] merged;

  // Decode of the live bus address, consumed on the setup edge.
  logic [ADDR_WIDTH-1:0] offset;
  logic                  live_err;
  logic [IDX_W-1:0]      live_idx;
  logic [CW-1:0]         wait_clamped;
  logic                  setup;

  assign offset   = paddr - BASE_ADDR;
  assign live_idx = IDX_W'(offset >> $clog2(NB));
`ifdef APB_SLAVE_PSTRB_EN
  assign live_err = (offset >= ADDR_WIDTH'(SPAN)) || ((paddr & ADDR_WIDTH'(NB - 1)) != '0)
                    || (!pwrite && (pstrb != '0));
`else
  assign live_err = (offset >= ADDR_WIDTH'(SPAN)) || ((paddr & ADDR_WIDTH'(NB - 1)) != '0);
`endif
  assign wait_clamped = ({1'b0, cfg_wait} > (CW+1)'(MAX_WAIT)) ? CW'(MAX_WAIT) : cfg_wait;
  assign setup        = psel && !penable;

  apb_slave_wait_ctr #(.WIDTH(CW)) u_wait_ctr (
    .clk        (clk),
    .reset      (reset),
    .clear      (ctr_clear),
    .load       (ctr_load),
    .inc        (ctr_inc),
    .load_value (wait_clamped),
    .tc_next    (ctr_tc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    pready_next  = 1'b0;
    pslverr_next = 1'b0;
    prdata_next  = '0;
    ctr_load     = 1'b0;
    ctr_clear    = 1'b0;
    ctr_inc      = 1'b0;
    mem_we       = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          state_next = ACCESS;
          ctr_load   = 1'b1;
          if (wait_clamped == '0) begin
            pready_next  = 1'b1;
            pslverr_next = live_err;
            prdata_next  = (live_err || pwrite) ? '0 : mem[live_idx];
          end
        end
      end
      ACCESS: begin
        if (!(psel && penable)) begin
          state_next = IDLE;
          ctr_clear  = 1'b1;
        end else if (pready) begin
          state_next = IDLE;
          ctr_clear  = 1'b1;
          mem_we     = write_reg && !err_reg;
        end else begin
          ctr_inc = 1'b1;
          if (ctr_tc_next) begin
            pready_next  = 1'b1;
            pslverr_next = err_reg;
            prdata_next  = (err_reg || write_reg) ? '0 : mem[idx_reg];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      pready  <= pready_next;
      pslverr <= pslverr_next;
      prdata  <= prdata_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg   <= '0;
      err_reg   <= 1'b0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
`ifdef APB_SLAVE_PSTRB_EN
      strb_reg  <= '0;
`endif
    end else if (ctr_load) begin
      idx_reg   <= live_idx;
      err_reg   <= live_err;
      write_reg <= pwrite;
      wdata_reg <= pwdata;
`ifdef APB_SLAVE_PSTRB_EN
      strb_reg  <= pstrb;
`endif
    end
  end

`ifdef APB_SLAVE_PSTRB_EN
  assign merged = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(mem[idx_reg]),
                                         MAX_DATA_WIDTH'(wdata_reg), BYTES'(strb_reg)));
`else
  assign merged = wdata_reg;
`endif

  // Register array rather than block RAM: every word must clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[idx_reg] <= merged;
    end
  end

endmodule
